// File: rtl/dsp_pkg.sv
// Shared constants for the DSP MAC pipeline: OPMODE bit positions and Z-select encodings.
package dsp_pkg;

  localparam int OPMODE_W   = 5;
  localparam int OP_PREADD  = 0;
  localparam int OP_PRESUB  = 1;
  localparam int OP_ZSEL_LO = 2;
  localparam int OP_ZSEL_HI = 3;
  localparam int OP_POSTSUB = 4;

  typedef enum logic [1:0] {
    ZSEL_ZERO = 2'b00,
    ZSEL_C    = 2'b01,
    ZSEL_P    = 2'b10,
    ZSEL_PCIN = 2'b11
  } zsel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Clock-enabled pipeline register with synchronous active-high reset to zero.
module dsp_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Reset dominates the enable so a reset edge always clears the stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else if (CE) begin
      Q <= D;
    end else begin
      Q <= Q;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Four-stage signed pre-add / multiply / post-add MAC with optional saturation,
// accumulate feedback from P and sticky overflow reporting.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int AW  = 18,
  parameter int BW  = 18,
  parameter int PW  = 48,
  parameter bit SAT = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CE,
  input  logic                IN_VALID,
  input  logic [AW-1:0]       A,
  input  logic [BW-1:0]       B,
  input  logic [BW-1:0]       D,
  input  logic [PW-1:0]       C,
  input  logic [PW-1:0]       PCIN,
  input  logic [OPMODE_W-1:0] OPMODE,
  output logic [PW-1:0]       P,
  output logic [PW-1:0]       PCOUT,
  output logic                OUT_VALID,
  output logic                OVF,
  output logic                OVF_STICKY
);

  localparam int MW  = AW + BW + 1;
  localparam int S1W = 1 + OPMODE_W + AW + 2 * BW + 2 * PW;
  localparam int S2W = 1 + 3 + AW + (BW + 1) + 2 * PW;
  localparam int S3W = 1 + 3 + MW + 2 * PW;
  localparam int S4W = 3 + PW;

  generate
    if (PW < AW + BW + 1) begin : g_bad_pw
      $error("dsp_mac_pipe: PW must be at least AW+BW+1");
    end
  endgenerate

  // ---------------- S1: input registers ----------------
  logic [S1W-1:0]      s1_d, s1_q;
  logic                v1_q;
  logic [OPMODE_W-1:0] op1_q;
  logic [AW-1:0]       a1_q;
  logic [BW-1:0]       b1_q, d1_q;
  logic [PW-1:0]       c1_q, pcin1_q;

  assign s1_d = {IN_VALID, OPMODE, A, B, D, C, PCIN};
  dsp_pipe_reg #(.WIDTH(S1W)) u_s1 (.CLK(CLK), .RST(RST), .CE(CE), .D(s1_d), .Q(s1_q));
  assign {v1_q, op1_q, a1_q, b1_q, d1_q, c1_q, pcin1_q} = s1_q;

  // ---------------- S2: pre-adder ----------------
  logic [BW:0] b_ext_s, d_ext_s, pre_d;

  assign b_ext_s = {b1_q[BW-1], b1_q};
  assign d_ext_s = {d1_q[BW-1], d1_q};

  // Pre-adder is one bit wider than B/D so D+B and D-B never overflow.
  always_comb begin
    pre_d = b_ext_s;
    if (op1_q[OP_PREADD]) begin
      if (op1_q[OP_PRESUB]) begin
        pre_d = d_ext_s - b_ext_s;
      end else begin
        pre_d = d_ext_s + b_ext_s;
      end
    end else begin
      pre_d = b_ext_s;
    end
  end

  // Only the post-adder controls are still needed downstream of S1.
  logic [S2W-1:0] s2_d, s2_q;
  logic           v2_q, postsub2_q;
  logic [1:0]     zsel2_q;
  logic [AW-1:0]  a2_q;
  logic [BW:0]    pre2_q;
  logic [PW-1:0]  c2_q, pcin2_q;

  assign s2_d = {v1_q, op1_q[OP_POSTSUB], op1_q[OP_ZSEL_HI:OP_ZSEL_LO], a1_q, pre_d, c1_q, pcin1_q};
  dsp_pipe_reg #(.WIDTH(S2W)) u_s2 (.CLK(CLK), .RST(RST), .CE(CE), .D(s2_d), .Q(s2_q));
  assign {v2_q, postsub2_q, zsel2_q, a2_q, pre2_q, c2_q, pcin2_q} = s2_q;

  // ---------------- S3: multiplier ----------------
  logic [MW-1:0] a_ext_s, pre_ext_s, prod_d;

  assign a_ext_s   = {{(BW + 1){a2_q[AW-1]}}, a2_q};
  assign pre_ext_s = {{AW{pre2_q[BW]}}, pre2_q};
  assign prod_d    = a_ext_s * pre_ext_s;

  logic [S3W-1:0] s3_d, s3_q;
  logic           v3_q, postsub3_q;
  logic [1:0]     zsel3_q;
  logic [MW-1:0]  prod3_q;
  logic [PW-1:0]  c3_q, pcin3_q;

  assign s3_d = {v2_q, postsub2_q, zsel2_q, prod_d, c2_q, pcin2_q};
  dsp_pipe_reg #(.WIDTH(S3W)) u_s3 (.CLK(CLK), .RST(RST), .CE(CE), .D(s3_d), .Q(s3_q));
  assign {v3_q, postsub3_q, zsel3_q, prod3_q, c3_q, pcin3_q} = s3_q;

  // ---------------- S4: Z select, post-adder, P register ----------------
  logic [S4W-1:0] s4_d, s4_q;
  logic           out_valid_q, ovf_q, sticky_q, ovf_d, sticky_d;
  logic [PW-1:0]  p_q, p_d, z_s, res_s, sat_s;
  logic [PW:0]    z_ext_s, m_ext_s, sum_s;
  logic           ovf_s;

  // Z source; ZSEL_P feeds back the live P so back-to-back accumulation needs no stall.
  always_comb begin
    z_s = '0;
    case (zsel_e'(zsel3_q))
      ZSEL_ZERO: z_s = '0;
      ZSEL_C:    z_s = c3_q;
      ZSEL_P:    z_s = p_q;
      ZSEL_PCIN: z_s = pcin3_q;
      default:   z_s = '0;
    endcase
  end

  assign z_ext_s = {z_s[PW-1], z_s};
  assign m_ext_s = {{(PW - AW - BW){prod3_q[MW-1]}}, prod3_q};
  assign sum_s   = postsub3_q ? (z_ext_s - m_ext_s) : (z_ext_s + m_ext_s);
  assign ovf_s   = sum_s[PW] ^ sum_s[PW-1];
  assign sat_s   = sum_s[PW] ? {1'b1, {(PW - 1){1'b0}}} : {1'b0, {(PW - 1){1'b1}}};

  // P, OVF and the sticky flag only move when a valid sample leaves S3.
  always_comb begin
    res_s    = sum_s[PW-1:0];
    p_d      = p_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    if (ovf_s && SAT) begin
      res_s = sat_s;
    end else begin
      res_s = sum_s[PW-1:0];
    end
    if (v3_q) begin
      p_d      = res_s;
      ovf_d    = ovf_s;
      sticky_d = sticky_q | ovf_s;
    end else begin
      p_d      = p_q;
      ovf_d    = ovf_q;
      sticky_d = sticky_q;
    end
  end

  assign s4_d = {v3_q, ovf_d, sticky_d, p_d};
  dsp_pipe_reg #(.WIDTH(S4W)) u_s4 (.CLK(CLK), .RST(RST), .CE(CE), .D(s4_d), .Q(s4_q));
  assign {out_valid_q, ovf_q, sticky_q, p_q} = s4_q;

  assign P          = p_q;
  assign PCOUT      = p_q;
  assign OUT_VALID  = out_valid_q;
  assign OVF        = ovf_q;
  assign OVF_STICKY = sticky_q;

endmodule
